// File: rtl/bytewrite_ram_pkg.sv
// ---------------------------------------------------------------------------
// bytewrite_ram_pkg
// Shared definitions for the byte-write RAM request initiator:
//   - default geometry of the RAM word (lanes, lane width, address bits)
//   - depth of the response buffer (RSP_DEPTH)
//   - the response entry carried through the buffer
//   - a modulo-RSP_DEPTH pointer increment helper
// ---------------------------------------------------------------------------
package bytewrite_ram_pkg;

    localparam int DEF_NUM_COL    = 4;
    localparam int DEF_COL_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = DEF_NUM_COL * DEF_COL_WIDTH;

    localparam int RSP_DEPTH = 3;

    typedef struct packed {
        logic                      write;
        logic [DEF_DATA_WIDTH-1:0] rdata;
    } rsp_entry_t;

    // Pointers run 0,1,2,0,... because the depth is not a power of two.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(RSP_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/bytewrite_rsp_fifo.sv
// ---------------------------------------------------------------------------
// bytewrite_rsp_fifo
// Three-entry in-order response buffer with simultaneous push and pop.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push          write push_data into the tail at the next edge
//   push_data     response entry {write, rdata}
//   pop           drop the head entry at the next edge
//   out_valid     buffer holds at least one entry
//   head          entry at the head (all zero after reset)
//   count         number of stored entries, 0..3
// ---------------------------------------------------------------------------
module bytewrite_rsp_fifo
    import bytewrite_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rsp_entry_t push_data,
    input  logic       pop,
    output logic       out_valid,
    output rsp_entry_t head,
    output logic [1:0] count
);

    rsp_entry_t mem_q [RSP_DEPTH];
    rsp_entry_t mem_d [RSP_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push;
    logic       do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // The initiator's credit rule keeps push away from a full buffer;
        // the guards only make the buffer safe as a standalone block.
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'(RSP_DEPTH)) || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/bytewrite_ram_initiator.sv
// ---------------------------------------------------------------------------
// bytewrite_ram_initiator
// Turns a valid/ready stream of read / byte-masked write requests into the
// port signals of a read-first byte-write single-port RAM with a one-cycle
// registered output, and returns the pre-access RAM word of every access on
// a valid/ready response stream.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_write, req_be,
//   req_addr, req_wdata            request payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_write, rsp_rdata           response payload (echoed write flag, old word)
//   ram_ena, ram_we, ram_addr,
//   ram_din                        RAM drive
//   ram_dout                       RAM registered output
// ---------------------------------------------------------------------------
module bytewrite_ram_initiator
    import bytewrite_ram_pkg::*;
#(
    parameter int NUM_COL    = DEF_NUM_COL,
    parameter int COL_WIDTH  = DEF_COL_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [NUM_COL-1:0]    req_be,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_ena,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic       accept;
    logic       inflight_q, inflight_d;
    logic       inflight_write_q, inflight_write_d;
    logic [1:0] fifo_count;
    logic [2:0] outstanding;
    rsp_entry_t push_entry;
    rsp_entry_t head_entry;
    logic       fifo_valid;

    // Credit: every accepted access owns a buffer slot from accept until pop,
    // so the buffer can never overflow. Only registered state feeds this.
    assign outstanding = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign req_ready   = (outstanding < 3'(RSP_DEPTH));
    assign accept      = req_valid && req_ready;

    assign ram_ena  = accept;
    assign ram_we   = (accept && req_write) ? req_be : '0;
    assign ram_addr = req_addr;
    assign ram_din  = req_wdata;

    // The inflight flag marks the cycle in which ram_dout holds the word read
    // by the previous accept; that is the only cycle the word is captured.
    always_comb begin
        inflight_d       = accept;
        inflight_write_d = inflight_write_q;
        if (accept) begin
            inflight_write_d = req_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q       <= 1'b0;
            inflight_write_q <= 1'b0;
        end else begin
            inflight_q       <= inflight_d;
            inflight_write_q <= inflight_write_d;
        end
    end

    assign push_entry.write = inflight_write_q;
    assign push_entry.rdata = ram_dout;

    bytewrite_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (push_entry),
        .pop       (rsp_valid && rsp_ready),
        .out_valid (fifo_valid),
        .head      (head_entry),
        .count     (fifo_count)
    );

    assign rsp_valid = fifo_valid;
    assign rsp_write = head_entry.write;
    assign rsp_rdata = head_entry.rdata;

endmodule

// File: tb/tb_bytewrite_ram_initiator.sv
// ---------------------------------------------------------------------------
// tb_bytewrite_ram_initiator
// Drives the initiator against a read-first byte-write RAM model. A reference
// memory predicts the old word of each accepted access; predictions are
// queued with their accept cycle and compared by the monitor when the DUT
// presents responses.
// ---------------------------------------------------------------------------
module tb_bytewrite_ram_initiator;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int AW = 10;
    localparam int DW = NC * CW;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [NC-1:0] req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          ram_ena;
    logic [NC-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] ram_mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_ready_en = 0;

    bytewrite_ram_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .ram_ena   (ram_ena),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first byte-write RAM with registered output.
    initial ram_dout = '0;
    always @(posedge clk) begin
        if (ram_ena) begin
            ram_dout <= ram_mem[ram_addr];
            for (int i = 0; i < NC; i++) begin
                if (ram_we[i]) ram_mem[ram_addr][i*CW +: CW] <= ram_din[i*CW +: CW];
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: predicts handshake outputs from the outstanding-request count,
    // compares the head response, and records predictions for new accepts.
    exp_t mon_e;
    bit   mon_acc;
    bit   mon_expv;
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("req_ready", {63'b0, req_ready}, {63'b0, sb_q.size() < 3});
            mon_expv = (sb_q.size() > 0) && (sb_q[0].cyc + 2 <= cyc);
            checkOutput("rsp_valid", {63'b0, rsp_valid}, {63'b0, mon_expv});
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got data 0x%0h, expected no response (cycle %0d)", rsp_rdata, cyc);
                end else begin
                    checkOutput("rsp_write", {63'b0, rsp_write}, {63'b0, sb_q[0].write});
                    checkOutput("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, sb_q[0].rdata});
                    if (rsp_ready) void'(sb_q.pop_front());
                end
            end
            mon_acc = req_valid && req_ready;
            checkOutput("ram_ena", {63'b0, ram_ena}, {63'b0, mon_acc});
            checkOutput("ram_we", {60'b0, ram_we}, {60'b0, (mon_acc && req_write) ? req_be : 4'b0});
            if (mon_acc) begin
                checkOutput("ram_addr", {54'b0, ram_addr}, {54'b0, req_addr});
                checkOutput("ram_din", {32'b0, ram_din}, {32'b0, req_wdata});
                mon_e.write = req_write;
                mon_e.rdata = ref_mem[req_addr];
                mon_e.cyc   = cyc;
                for (int i = 0; i < NC; i++) begin
                    if (req_write && req_be[i]) ref_mem[req_addr][i*CW +: CW] = req_wdata[i*CW +: CW];
                end
                sb_q.push_back(mon_e);
            end
        end
    end

    // Presents one request (called at posedge+1) and returns at posedge+1
    // after its accept edge with req_valid still asserted.
    task automatic applyStimulus(input logic w, input logic [NC-1:0] be, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, output int waited);
        bit done;
        done      = 0;
        waited    = 0;
        req_valid = 1'b1;
        req_write = w;
        req_be    = be;
        req_addr  = a;
        req_wdata = d;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (req_ready) done = 1;
            else waited++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_timeout: request at 0x%0h never accepted", a);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_be    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d responses left, expected 0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int            waited;
    int            nacc;
    logic [DW-1:0] v;

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        idle();
        for (int i = 0; i < (1 << AW); i++) begin
            v          = $urandom;
            ram_mem[i] = v;
            ref_mem[i] = v;
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        checkOutput("rst_rsp_write", {63'b0, rsp_write}, 64'd0);
        checkOutput("rst_rsp_rdata", {32'b0, rsp_rdata}, 64'd0);
        checkOutput("rst_ram_ena", {63'b0, ram_ena}, 64'd0);
        checkOutput("rst_ram_we", {60'b0, ram_we}, 64'd0);
        checkOutput("rst_ram_addr", {54'b0, ram_addr}, 64'd0);
        checkOutput("rst_ram_din", {32'b0, ram_din}, 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_req_ready", {63'b0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;

        $display("[TB] full write then read");
        applyStimulus(1'b1, 4'hF, 10'h005, 32'h11223344, waited);
        applyStimulus(1'b0, 4'h0, 10'h005, 32'h0, waited);
        idle();
        drain();

        $display("[TB] partial writes and empty byte mask");
        applyStimulus(1'b1, 4'hF, 10'h010, 32'hAABBCCDD, waited);
        applyStimulus(1'b1, 4'b0101, 10'h010, 32'h00990088, waited);
        applyStimulus(1'b0, 4'h0, 10'h010, 32'h0, waited);
        applyStimulus(1'b1, 4'h0, 10'h010, 32'hFFFFFFFF, waited);
        applyStimulus(1'b0, 4'h0, 10'h010, 32'h0, waited);
        idle();
        drain();

        $display("[TB] streaming reads");
        nacc = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 4'h0, AW'(10'h020 + i), 32'h0, waited);
            nacc += waited;
        end
        idle();
        checkOutput("stream_stalls", 64'(nacc), 64'd0);
        drain();

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 10'h030;
        nacc      = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready) nacc++;
            @(posedge clk);
            #1;
            if (nacc > 0) req_addr = AW'(10'h030 + nacc);
        end
        idle();
        checkOutput("bp_accepts", 64'(nacc), 64'd3);
        checkOutput("bp_req_ready", {63'b0, req_ready}, 64'd0);
        rsp_ready = 1'b1;
        drain();

        $display("[TB] simultaneous push and pop");
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, AW'(10'h040 + i), 32'h0, waited);
        idle();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pushpop_req_ready", {63'b0, req_ready}, 64'd1);
        checkOutput("pushpop_rsp_valid", {63'b0, rsp_valid}, 64'd1);
        drain();

        $display("[TB] reset with responses outstanding");
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, AW'(10'h050 + i), 32'h0, waited);
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_req_ready", {63'b0, req_ready}, 64'd1);
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        rand_ready_en = 1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom_range(0, 15)), $urandom, waited);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        idle();
        rand_ready_en = 0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
